// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_pick4.sv
// Rotating-priority picker: first unmasked requester scanning ptr, ptr+1, .. ptr+3.
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] eligible;
  logic [SEL_W-1:0]   cand;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    eligible = req & ~mask;
    found    = 1'b0;
    idx      = '0;
    cand     = '0;
    // Walk from the farthest offset back to ptr so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter granting one downstream port to 4 requesters, holding the
// grant across a multi-beat transaction and handing over with no idle gap.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  input  logic [DATA_WIDTH-1:0] req_data2,
  input  logic [DATA_WIDTH-1:0] req_data3,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic               overrun_nxt;

  logic               busy;
  logic               xfer;
  logic               cnt_full;
  logic               release_now;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  assign busy      = (state == ST_BUSY);
  assign xfer      = out_valid & out_ready;
  assign cnt_full  = (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BEATS);
  // Abort when the owner withdraws, otherwise release on a last or capped beat.
  assign release_now = busy & (~req[sel] | (xfer & (req_last[sel] | cnt_full)));
  // The releasing owner is excluded so it cannot be re-granted back-to-back.
  assign pick_mask = busy ? onehot(sel) : '0;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      overrun  <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    overrun_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt    = ST_BUSY;
          sel_nxt      = pick_idx;
          ptr_nxt      = pick_idx + SEL_W'(1);
          beat_cnt_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          beat_cnt_nxt = '0;
          overrun_nxt  = xfer & cnt_full & ~req_last[sel];
          if (pick_found) begin
            sel_nxt = pick_idx;
            ptr_nxt = pick_idx + SEL_W'(1);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = busy & req[sel] & ~reset;
    out_last  = req_last[sel] & out_valid;
    ack       = (out_valid & out_ready) ? onehot(sel) : '0;
    gnt       = busy ? onehot(sel) : '0;
    unique case (sel)
      2'd0:    out_data = req_data0;
      2'd1:    out_data = req_data1;
      2'd2:    out_data = req_data2;
      default: out_data = req_data3;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: grant latency, rotation, stalls, cap, abort, reset.
module tb_rr_arbiter_4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_last;
  logic [31:0] dat [4];
  logic [3:0]  ack, gnt;
  logic [1:0]  sel;
  logic        out_valid, out_last, out_ready, overrun;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.DATA_WIDTH(32), .MAX_BEATS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_last  (req_last),
    .req_data0 (dat[0]),
    .req_data1 (dat[1]),
    .req_data2 (dat[2]),
    .req_data3 (dat[3]),
    .ack       (ack),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_last = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
    total++; if (dut.beat_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dut.beat_cnt); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; req_last = 4'b0001; out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_idle_ack: got %b want 0000", ack); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack: got %b want 0001", ack); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", out_last); end
    total++; if (out_data !== 32'hA000_0000) begin bad++; $display("FAIL single_data: got %h want a0000000", out_data); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_idle_after: got %b want 0000", gnt); end
  endtask

  task automatic test_rotation();
    int exp_i [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_d;
    logic [3:0]  exp_g;
    do_reset();
    req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rot_bubble: got %b want 0000", gnt); end
    tick();
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << exp_i[n];
      exp_d = 32'hA000_0000 + 32'(exp_i[n]);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rot_gnt[%0d]: got %b want %b", n, gnt, exp_g); end
      total++; if (ack !== exp_g) begin bad++; $display("FAIL rot_ack[%0d]: got %b want %b", n, ack, exp_g); end
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL rot_data[%0d]: got %h want %h", n, out_data, exp_d); end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_stall_burst();
    int beats = 0;
    logic [3:0] exp_ack;
    do_reset();
    req = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      out_ready = (c % 2 == 0);
      req_last  = (beats == 3) ? 4'b0010 : 4'b0000;
      #1;
      exp_ack = out_ready ? 4'b0010 : 4'b0000;
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt[%0d]: got %b want 0010", c, gnt); end
      total++; if (ack !== exp_ack) begin bad++; $display("FAIL stall_ack[%0d]: got %b want %b", c, ack, exp_ack); end
      total++; if (dut.beat_cnt !== 5'(beats)) begin bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", c, dut.beat_cnt, beats); end
      total++; if (out_last !== (beats == 3)) begin bad++; $display("FAIL stall_last[%0d]: got %b want %b", c, out_last, beats == 3); end
      tick();
      if (out_ready) beats++;
    end
    // Sole requester after its last beat: one idle bubble, then re-granted.
    req_last = 4'b0000;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL stall_release: got %b want 0000", gnt); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL stall_bubble_ack: got %b want 0000", ack); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_regrant: got %b want 0010", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_max_beats();
    do_reset();
    req = 4'b1100; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 16; b++) begin
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL max_ack[%0d]: got %b want 0100", b, ack); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL max_early_overrun[%0d]: got %b want 0", b, overrun); end
      tick();
    end
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL max_handover: got %b want 1000", gnt); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL max_overrun: got %b want 1", overrun); end
    total++; if (dut.beat_cnt !== 5'd0) begin bad++; $display("FAIL max_cnt_clear: got %0d want 0", dut.beat_cnt); end
    req = 4'b0000;
    tick();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL max_pulse_width: got %b want 0", overrun); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL max_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b1000; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL abort_ack0: got %b want 1000", ack); end
    tick();
    total++; if (dut.beat_cnt !== 5'd1) begin bad++; $display("FAIL abort_cnt: got %0d want 1", dut.beat_cnt); end
    req = 4'b1001;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL abort_hold: got %b want 1000", gnt); end
    req = 4'b0001; req_last = 4'b0001;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL abort_noack: got %b want 0000", ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL abort_gnt: got %b want 0001", gnt); end
    total++; if (dut.ptr !== 2'd1) begin bad++; $display("FAIL abort_ptr: got %0d want 1", dut.ptr); end
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL abort_next_ack: got %b want 0001", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    tick();
    total++; if (dut.beat_cnt !== 5'd2) begin bad++; $display("FAIL rst_pre_cnt: got %0d want 2", dut.beat_cnt); end
    reset = 1'b1;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL rst_ptr: got %0d want 0", dut.ptr); end
    total++; if (dut.beat_cnt !== 5'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", dut.beat_cnt); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_resume_gnt: got %b want 0010", gnt); end
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL rst_resume_ack: got %b want 0010", ack); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b1; req = '0; req_last = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_stall_burst();
    test_max_beats();
    test_abort();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
